// File: rtl/y_mux_rr.sv
// y_mux_rr: N-channel, W-bit registered multiplexer with valid/ready on every
// input and on the output. Selection is either a fixed external index or a
// round-robin scan. One cycle of latency, back-pressure, and a wrapping count
// of completed output transfers.
module y_mux_rr #(
  parameter  int W    = 8,
  parameter  int N    = 4,
  parameter  int CNTW = 16,
  localparam int SELW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N*W-1:0]    in_data,
  input  logic [N-1:0]      in_valid,
  output logic [N-1:0]      in_ready,
  input  logic              mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic [SELW-1:0]   out_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNTW-1:0]   xfer_cnt
);

  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_chan_q, out_chan_d;
  logic            out_valid_q, out_valid_d;
  logic [CNTW-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;

  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic            load_en;
  logic            in_xfer;
  logic            out_xfer;
  logic [W-1:0]    load_data;

  // The output register can take a new beat when it is empty or being drained.
  assign load_en  = !out_valid_q || out_ready;
  assign in_xfer  = grant_vld && load_en && !reset;
  assign out_xfer = out_valid_q && out_ready;

  // Pick the channel to serve: the external index in fixed mode, otherwise the
  // first valid channel found scanning upward from the round-robin pointer.
  // The round-robin loop runs from the far end back toward the pointer so the
  // nearest valid channel is the last (and winning) assignment.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (mode) begin
      for (int k = N - 1; k >= 0; k--) begin
        if (in_valid[(int'(rr_ptr_q) + k) % N]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'((int'(rr_ptr_q) + k) % N);
        end
      end
    end else begin
      for (int c = 0; c < N; c++) begin
        if (sel == SELW'(c) && in_valid[c]) begin
          grant_vld = 1'b1;
          grant_idx = SELW'(c);
        end
      end
    end
  end

  // Extract the granted channel's data and raise ready only on that channel;
  // ready stays low during reset and whenever the output register is stalled.
  always_comb begin
    load_data = '0;
    in_ready  = '0;
    for (int c = 0; c < N; c++) begin
      if (grant_idx == SELW'(c)) begin
        load_data   = in_data[c*W +: W];
        in_ready[c] = in_xfer;
      end
    end
  end

  // Next-state for the output register, round-robin pointer and transfer count.
  // A load in the same cycle as a drain simply replaces the beat, keeping
  // out_valid high for full one-beat-per-cycle throughput.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    xfer_cnt_d  = xfer_cnt_q;
    rr_ptr_d    = rr_ptr_q;

    if (out_xfer) begin
      xfer_cnt_d  = xfer_cnt_q + CNTW'(1);
      out_valid_d = 1'b0;
    end

    if (in_xfer) begin
      out_data_d  = load_data;
      out_chan_d  = grant_idx;
      out_valid_d = 1'b1;
      if (mode) begin
        if (grant_idx == SELW'(N - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = grant_idx + SELW'(1);
        end
      end
    end
  end

  // State registers with synchronous reset; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      xfer_cnt_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      xfer_cnt_q  <= xfer_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_valid = out_valid_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_y_mux_rr.sv
// tb_y_mux_rr: directed bench for y_mux_rr (W=8, N=4, CNTW=4). Stimulus pushes
// the expected {channel, data} of every beat it causes; a negedge monitor pops
// and compares whenever the DUT completes an output transfer.
module tb_y_mux_rr;

  localparam int W    = 8;
  localparam int N    = 4;
  localparam int CNTW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*W-1:0] in_data;
  logic [N-1:0]  in_valid;
  logic [N-1:0]  in_ready;
  logic          mode;
  logic [1:0]    sel;
  logic [W-1:0]  out_data;
  logic [1:0]    out_chan;
  logic          out_valid;
  logic          out_ready;
  logic [CNTW-1:0] xfer_cnt;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_exp;

  y_mux_rr #(.W(W), .N(N), .CNTW(CNTW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt  (xfer_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic m,
                               input logic [1:0] s, input logic ordy);
    in_valid  = v;
    mode      = m;
    sel       = s;
    out_ready = ordy;
    #1;
  endtask

  task automatic setData(input int c, input logic [7:0] d);
    in_data[c*W +: W] = d;
  endtask

  task automatic expectBeat(input logic [1:0] c, input logic [7:0] d);
    exp_q.push_back({c, d});
  endtask

  // Scoreboard monitor: a beat that is valid and accepted at the coming edge
  // must match the oldest expected beat.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat actual=%0h expected=none at %0t",
                 {out_chan, out_data}, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("beat", {22'b0, out_chan, out_data}, {22'b0, mon_exp});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    logic [3:0] onehot;
    reset = 1'b1;
    in_data = '0;
    in_valid = 4'hF;
    mode = 1'b1;
    sel = 2'd0;
    out_ready = 1'b1;

    // Reset held two cycles with every input valid.
    repeat (2) begin
      tick();
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    end
    reset = 1'b0;
    applyStimulus(4'b0000, 1'b0, 2'd0, 1'b1);
    tick();
    checkOutput("post_rst_out_chan", 32'(out_chan), 32'd0);
    checkOutput("post_rst_out_data", 32'(out_data), 32'd0);
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Fixed select.
    setData(2, 8'hA5);
    applyStimulus(4'b0100, 1'b0, 2'd2, 1'b1);
    checkOutput("fix_in_ready", 32'(in_ready), 32'b0100);
    expectBeat(2'd2, 8'hA5);
    tick();
    checkOutput("fix_out_valid", 32'(out_valid), 32'd1);
    checkOutput("fix_out_data", 32'(out_data), 32'hA5);
    checkOutput("fix_out_chan", 32'(out_chan), 32'd2);
    applyStimulus(4'b0100, 1'b0, 2'd3, 1'b1);
    checkOutput("fix_sel3_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("fix_drop_out_valid", 32'(out_valid), 32'd0);
    checkOutput("fix_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // Round-robin fairness from a fresh reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < N; c++) setData(c, 8'(8'h10 + c));
    for (int i = 0; i < 8; i++) begin
      applyStimulus(4'hF, 1'b1, 2'd0, 1'b1);
      onehot = 4'b0001 << (i % 4);
      checkOutput("rr_in_ready", 32'(in_ready), 32'(onehot));
      expectBeat(2'(i % 4), 8'(8'h10 + (i % 4)));
      tick();
    end
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("rr_xfer_cnt", 32'(xfer_cnt), 32'd8);
    checkOutput("rr_out_valid", 32'(out_valid), 32'd0);

    // Skip and wrap: grant 2 leaves the pointer at 3; then 0, then 1.
    applyStimulus(4'b0100, 1'b1, 2'd0, 1'b1);
    checkOutput("rr_grant2", 32'(in_ready), 32'b0100);
    expectBeat(2'd2, 8'h12);
    tick();
    setData(0, 8'h20);
    setData(1, 8'h21);
    applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1);
    checkOutput("rr_wrap_grant0", 32'(in_ready), 32'b0001);
    expectBeat(2'd0, 8'h20);
    tick();
    applyStimulus(4'b0011, 1'b1, 2'd0, 1'b1);
    checkOutput("rr_next_grant1", 32'(in_ready), 32'b0010);
    expectBeat(2'd1, 8'h21);
    tick();
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("rr_skip_xfer_cnt", 32'(xfer_cnt), 32'd11);

    // Back-pressure: hold channel 1 beat 3C for three stalled cycles.
    setData(1, 8'h3C);
    applyStimulus(4'b0010, 1'b0, 2'd1, 1'b0);
    checkOutput("bp_load_ready", 32'(in_ready), 32'b0010);
    expectBeat(2'd1, 8'h3C);
    tick();
    for (int c = 0; c < N; c++) setData(c, 8'(8'h40 + c));
    repeat (3) begin
      applyStimulus(4'hF, 1'b1, 2'd1, 1'b0);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_out_chan", 32'(out_chan), 32'd1);
      checkOutput("bp_out_data", 32'(out_data), 32'h3C);
      checkOutput("bp_xfer_cnt", 32'(xfer_cnt), 32'd11);
      tick();
    end
    applyStimulus(4'hF, 1'b1, 2'd1, 1'b1);
    checkOutput("bp_release_ready", 32'(in_ready), 32'b0100);
    expectBeat(2'd2, 8'h42);
    tick();
    checkOutput("bp_release_cnt", 32'(xfer_cnt), 32'd12);
    checkOutput("bp_release_chan", 32'(out_chan), 32'd2);
    checkOutput("bp_release_data", 32'(out_data), 32'h42);
    checkOutput("bp_release_valid", 32'(out_valid), 32'd1);
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("bp_drain_cnt", 32'(xfer_cnt), 32'd13);

    // Counter wrap: 15 transfers from reset, then one more wraps to 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 0; c < N; c++) setData(c, 8'(8'h10 + c));
    for (int i = 0; i < 15; i++) begin
      applyStimulus(4'hF, 1'b1, 2'd0, 1'b1);
      expectBeat(2'(i % 4), 8'(8'h10 + (i % 4)));
      tick();
    end
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("wrap_pre_cnt", 32'(xfer_cnt), 32'd15);
    applyStimulus(4'b0001, 1'b1, 2'd0, 1'b1);
    checkOutput("wrap_in_ready", 32'(in_ready), 32'b0001);
    expectBeat(2'd0, 8'h10);
    tick();
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("wrap_cnt", 32'(xfer_cnt), 32'd0);

    // Reset while a beat is held: the beat is discarded.
    setData(1, 8'h77);
    applyStimulus(4'b0010, 1'b1, 2'd0, 1'b0);
    checkOutput("midrst_load_ready", 32'(in_ready), 32'b0010);
    tick();
    checkOutput("midrst_held_valid", 32'(out_valid), 32'd1);
    checkOutput("midrst_held_data", 32'(out_data), 32'h77);
    reset = 1'b1;
    applyStimulus(4'hF, 1'b1, 2'd0, 1'b0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_out_data", 32'(out_data), 32'd0);
    checkOutput("midrst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    reset = 1'b0;
    applyStimulus(4'b0000, 1'b1, 2'd0, 1'b1);
    tick();
    checkOutput("midrst_after_valid", 32'(out_valid), 32'd0);

    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/y_mux_rr.md
Name: y_mux_rr

Overview:
- Parametrised successor to the 1-bit 2:1 mux: N-channel, W-bit registered multiplexer with valid/ready handshaking on every input and on the output.
- Selection is either fixed (external select) or round-robin arbitrated.
- Sits between multiple producer stages and a single consumer in the datapath.
- Provides one-cycle registered latency, back-pressure and a transfer counter.

Parameters:
- W, 8, data width per channel in bits (W >= 1).
- N, 4, number of input channels (N >= 2).
- SELW, $clog2(N), channel index width; derived, never overridden.
- CNTW, 16, width of the transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*W  channel c occupies bits [c*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational; at most one bit high per cycle.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used when mode=0; values >= N select nothing.
- out_data  output  W  registered output data.
- out_chan  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  consumer accepts the beat when high together with out_valid.
- xfer_cnt  output  CNTW  count of completed output transfers; wraps modulo 2^CNTW.

Behaviour:
- Reset (reset=1 at a clk edge): out_valid=0, out_data=0, out_chan=0, xfer_cnt=0, rr_ptr=0. in_ready is all-zero while reset is high. Reset has priority over every other event.
- load_en = !out_valid | out_ready. The output register accepts a new beat only when load_en=1.
- Grant, mode=0: grant channel sel if sel < N and in_valid[sel]=1. Otherwise there is no grant.
- Grant, mode=1: grant the first c with in_valid[c]=1, scanning rr_ptr, rr_ptr+1, … modulo N. If no channel is valid, there is no grant.
- in_ready[g] = load_en & grant-valid for the granted channel g. All other in_ready bits are 0.
- An input transfer occurs on channel g when in_valid[g] & in_ready[g]. At the next edge: out_data <= in_data[g]; out_chan <= g; out_valid <= 1.
- Round-robin pointer: on an input transfer with mode=1, rr_ptr <= (g+1) mod N, with wrap at N-1 going to 0. In mode=0, rr_ptr holds its value.
- Output transfer: out_valid & out_ready at the edge increments xfer_cnt by 1. If no input transfer happens in the same cycle, out_valid <= 0.
- Simultaneous drain and load in one cycle: the new beat replaces the old one, out_valid stays 1, and xfer_cnt still increments. Full throughput is 1 beat/cycle.
- Back-pressure (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold stable, and all in_ready bits are 0.
- A mode or sel change takes effect on the grant decision in the same cycle. A beat already held in the output register is unaffected.
- Latency: 1 cycle from input transfer to out_valid.
- Data is never duplicated or dropped. Input data is sampled only at the transfer edge.
- Reset mid-operation: a held beat is discarded and xfer_cnt clears to 0.

Test Plan (W=8, N=4):
- Reset: hold reset 2 cycles with in_valid=4'b1111 -> out_valid=0, xfer_cnt=0, in_ready=0 throughout. After release, out_chan=0 and out_data=0.
- Fixed mode: mode=0, sel=2, in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=A5, out_chan=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> in_ready=0 and out_valid drops after 1 cycle.
- Round-robin fairness: mode=1, in_valid=4'b1111 held, channel c data = 8'h10+c, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 and data 10,11,12,13,10,11,12,13. Afterwards xfer_cnt=8.
- RR skip and wrap: rr_ptr=3 (after a grant of 2), in_valid=4'b0011 -> grant 0, then grant 1.
- Back-pressure: out_valid=1 with out_chan=1 and data=8'h3C, out_ready=0 for 3 cycles with all inputs valid -> outputs stable, in_ready=0, xfer_cnt unchanged. On out_ready=1, the next beat loads the same cycle and xfer_cnt increments by 1.
- Counter wrap and mid-run reset: preload via 65535 transfers (or CNTW=4 and 15 transfers), then one more -> xfer_cnt=0. Assert reset while out_valid=1 -> beat discarded and out_valid=0 next cycle.
